s100_io_responder: RTL and testbench



---
 rtl/s100_pkg.sv | 34 +++
 rtl/s100_sync.sv | 25 ++
 rtl/s100_io_responder.sv | 145 ++++++++++++++
 tb/tb_s100_io_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/s100_pkg.sv
// Shared types and constants for the S-100 I/O port responder.
// Defines the FSM states, the port offsets and the layout of the status byte.
package s100_pkg;

   typedef enum logic [1:0] {IDLE, WAIT_RD, DRIVE, WAIT_WR} state_t;

   localparam logic OFS_DATA = 1'b0;
   localparam logic OFS_STAT = 1'b1;

   localparam int STAT_ERR_BIT = 7;
   localparam int STAT_CNT_W   = 4;

   // Synchronized strobe/status bundle, MSB first.
   typedef struct packed {
      logic sout;
      logic sinp;
      logic n_pwr;
      logic pdbin;
      logic n_pstval;
      logic psync;
   } ctl_t;

   // Idle bus levels: active-low strobes sit high.
   localparam logic [5:0] CTL_IDLE = 6'b001010;

   function automatic logic [7:0] stat_byte(input logic err, input logic [STAT_CNT_W-1:0] cnt);
      logic [7:0] b;
      b = '0;
      b[STAT_ERR_BIT] = err;
      b[STAT_CNT_W-1:0] = cnt;
      return b;
   endfunction

endpackage

// File: rtl/s100_sync.sv
// Two-flop synchronizer, W bits wide, reset to RST_VAL.
// Latency 2 clocks; no backpressure, samples every clock.
module s100_sync #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/s100_io_responder.sv
// S-100 slave I/O responder: data port at PORT_BASE, status port at PORT_BASE+1.
// Strobe edges act on the 3rd clock after they occur; no backpressure, the bus master paces every cycle.
module s100_io_responder
   import s100_pkg::*;
#(
   parameter logic [7:0]  PORT_BASE = 8'h30,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic       pll0_50MHz,
   input  logic       s100_n_RESET,
   input  logic [7:0] s100_adr,
   input  logic [7:0] s100_DO,
   input  logic       s100_pSYNC,
   input  logic       s100_n_pSTVAL,
   input  logic       s100_pDBIN,
   input  logic       s100_n_pWR,
   input  logic       s100_sINP,
   input  logic       s100_sOUT,
   output logic [7:0] s100_DI,
   output logic       F_out_DI_oe,
   output logic [7:0] port_data,
   output logic [7:0] sbcLEDS,
   output logic [7:0] cycle_count,
   output logic       timeout_err
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   // Reset asserts asynchronously and releases on the clock.
   logic [1:0] rst_pipe;
   logic       rst_n;

   always_ff @(posedge pll0_50MHz or negedge s100_n_RESET) begin
      if (!s100_n_RESET) rst_pipe <= 2'b00;
      else               rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_n = rst_pipe[1];

   logic [7:0] adr_s;
   logic [7:0] do_s;
   ctl_t       ctl_raw;
   ctl_t       ctl_s;

   assign ctl_raw = {s100_sOUT, s100_sINP, s100_n_pWR, s100_pDBIN, s100_n_pSTVAL, s100_pSYNC};

   s100_sync #(.W(8), .RST_VAL(8'h00)) u_sync_adr (
      .clk(pll0_50MHz), .rst_n(rst_n), .d(s100_adr), .q(adr_s));
   s100_sync #(.W(8), .RST_VAL(8'h00)) u_sync_do (
      .clk(pll0_50MHz), .rst_n(rst_n), .d(s100_DO), .q(do_s));
   s100_sync #(.W(6), .RST_VAL(CTL_IDLE)) u_sync_ctl (
      .clk(pll0_50MHz), .rst_n(rst_n), .d(ctl_raw), .q(ctl_s));

   logic   qual_q, dbin_q, n_pwr_q;
   logic   qual, start, dbin_rise, dbin_fall, wr_rise, hit;
   state_t state, decoded;
   logic   rd_stat;
   logic [15:0] tmo_cnt;
   logic [7:0]  hold;

   assign qual      = ctl_s.psync & ~ctl_s.n_pstval;
   assign dbin_rise = ctl_s.pdbin & ~dbin_q;
   assign dbin_fall = ~ctl_s.pdbin & dbin_q;
   assign wr_rise   = ctl_s.n_pwr & ~n_pwr_q;
   assign hit       = (adr_s[7:1] == PORT_BASE[7:1]);

   // IDLE decodes on the qualified level; a wait state only restarts on a fresh qualification.
   always_comb begin
      start = 1'b0;
      case (state)
         IDLE:             start = qual;
         WAIT_RD, WAIT_WR: start = qual & ~qual_q;
         default:          start = 1'b0;
      endcase
   end

   always_comb begin
      decoded = IDLE;
      if (hit && ctl_s.sinp && !ctl_s.sout)
         decoded = WAIT_RD;
      else if (hit && ctl_s.sout && !ctl_s.sinp && adr_s[0] == OFS_DATA)
         decoded = WAIT_WR;
   end

   always_ff @(posedge pll0_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         qual_q      <= 1'b0;
         dbin_q      <= 1'b0;
         n_pwr_q     <= 1'b1;
         rd_stat     <= 1'b0;
         tmo_cnt     <= '0;
         hold        <= '0;
         s100_DI     <= '0;
         F_out_DI_oe <= 1'b1;
         port_data   <= '0;
         cycle_count <= '0;
         timeout_err <= 1'b0;
      end else begin
         qual_q  <= qual;
         dbin_q  <= ctl_s.pdbin;
         n_pwr_q <= ctl_s.n_pwr;
         if (state == WAIT_WR && !ctl_s.n_pwr)
            hold <= do_s;

         if (start) begin
            state   <= decoded;
            rd_stat <= adr_s[0];
            tmo_cnt <= '0;
         end else begin
            case (state)
               WAIT_RD, WAIT_WR: begin
                  if (state == WAIT_RD && dbin_rise) begin
                     s100_DI     <= (rd_stat == OFS_STAT)
                                    ? stat_byte(timeout_err, cycle_count[STAT_CNT_W-1:0])
                                    : port_data;
                     F_out_DI_oe <= 1'b0;
                     state       <= DRIVE;
                  end else if (state == WAIT_WR && wr_rise) begin
                     port_data   <= hold;
                     cycle_count <= cycle_count + 8'd1;
                     state       <= IDLE;
                  end else if (tmo_cnt == TMO_LAST) begin
                     timeout_err <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     tmo_cnt <= tmo_cnt + 16'd1;
                  end
               end
               DRIVE: begin
                  if (dbin_fall) begin
                     F_out_DI_oe <= 1'b1;
                     s100_DI     <= '0;
                     cycle_count <= cycle_count + 8'd1;
                     state       <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign sbcLEDS = ~port_data;

endmodule

// File: tb/tb_s100_io_responder.sv
// Bench for s100_io_responder: transaction-level model of the port window plus directed and random bus cycles.
module tb_s100_io_responder;

   logic       clk;
   logic       n_reset;
   logic [7:0] adr, dout;
   logic       psync, n_pstval, pdbin, n_pwr, sinp, sout;
   logic [7:0] di, port_data, leds, cnt;
   logic       di_oe, tmo_err;

   s100_io_responder #(.PORT_BASE(8'h30), .TIMEOUT(20)) dut (
      .pll0_50MHz(clk), .s100_n_RESET(n_reset), .s100_adr(adr), .s100_DO(dout),
      .s100_pSYNC(psync), .s100_n_pSTVAL(n_pstval), .s100_pDBIN(pdbin), .s100_n_pWR(n_pwr),
      .s100_sINP(sinp), .s100_sOUT(sout), .s100_DI(di), .F_out_DI_oe(di_oe),
      .port_data(port_data), .sbcLEDS(leds), .cycle_count(cnt), .timeout_err(tmo_err));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: what the port window must hold after every completed bus cycle.
   logic [7:0] m_port = 8'h00;
   logic [7:0] m_cnt  = 8'h00;
   logic       m_err  = 1'b0;
   logic       chk_en = 1'b0;
   logic [7:0] got;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic is_rd(input logic [7:0] a, input logic i, input logic o);
      return (a[7:1] == 7'h18) && i && !o;
   endfunction

   function automatic logic is_wr(input logic [7:0] a, input logic i, input logic o);
      return (a == 8'h30) && o && !i;
   endfunction

   function automatic logic [7:0] status_byte();
      return {m_err, 3'b000, m_cnt[3:0]};
   endfunction

   // Between bus cycles every output must match the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("idle_port", port_data, m_port);
         chk("idle_leds", leds, 8'(~m_port));
         chk("idle_cnt", cnt, m_cnt);
         chk("idle_err", tmo_err, m_err);
         chk("idle_oe", di_oe, 1);
         chk("idle_di", di, 0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_idle();
      psync = 1'b0; n_pstval = 1'b1; pdbin = 1'b0; n_pwr = 1'b1;
      sinp = 1'b0; sout = 1'b0;
   endtask

   // Returns on the negedge just after the responder has decoded the cycle.
   task automatic start_cycle(input logic [7:0] a, input logic i, input logic o);
      chk_en = 1'b0;
      adr = a; sinp = i; sout = o;
      psync = 1'b1; n_pstval = 1'b0;
      tick(3);
      psync = 1'b0; n_pstval = 1'b1;
   endtask

   task automatic end_cycle();
      bus_idle();
      tick(4);
      chk_en = 1'b1;
      tick(2);
   endtask

   task automatic write_txn(input logic [7:0] a, input logic i, input logic o,
                            input logic [7:0] d, input int width);
      logic [7:0] old_port;
      start_cycle(a, i, o);
      dout = d; n_pwr = 1'b0;
      tick(width);
      n_pwr = 1'b1; dout = 8'($urandom);
      old_port = m_port;
      tick(2);
      chk("wr_before_commit", port_data, old_port);
      tick(1);
      if (is_wr(a, i, o)) begin
         m_port = d;
         m_cnt++;
      end
      chk("wr_commit_port", port_data, m_port);
      chk("wr_commit_cnt", cnt, m_cnt);
      chk("wr_oe", di_oe, 1);
      end_cycle();
   endtask

   task automatic read_txn(input logic [7:0] a, input logic i, input logic o,
                           input int width, output logic [7:0] di_seen);
      logic       hit;
      logic [7:0] exp_di;
      start_cycle(a, i, o);
      hit    = is_rd(a, i, o);
      exp_di = a[0] ? status_byte() : m_port;
      pdbin = 1'b1;
      tick(2);
      chk("rd_oe_before", di_oe, 1);
      tick(1);
      chk("rd_oe_on", di_oe, hit ? 0 : 1);
      if (hit) chk("rd_di", di, exp_di);
      di_seen = di;
      tick(width - 3);
      pdbin = 1'b0;
      tick(2);
      chk("rd_oe_hold", di_oe, hit ? 0 : 1);
      tick(1);
      if (hit) m_cnt++;
      chk("rd_oe_off", di_oe, 1);
      chk("rd_di_off", di, 0);
      chk("rd_cnt", cnt, m_cnt);
      end_cycle();
   endtask

   task automatic timeout_txn(input logic [7:0] a, input logic i, input logic o);
      start_cycle(a, i, o);
      tick(19);
      chk("tmo_before", tmo_err, m_err);
      tick(1);
      if (is_rd(a, i, o) || is_wr(a, i, o)) m_err = 1'b1;
      chk("tmo_after", tmo_err, m_err);
      chk("tmo_cnt", cnt, m_cnt);
      end_cycle();
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      bus_idle();
      n_reset = 1'b0;
      tick(5);
      chk("rst_di", di, 0);
      chk("rst_oe", di_oe, 1);
      chk("rst_port", port_data, 0);
      chk("rst_leds", leds, 8'hFF);
      chk("rst_cnt", cnt, 0);
      chk("rst_err", tmo_err, 0);
      m_port = 8'h00; m_cnt = 8'h00; m_err = 1'b0;
      n_reset = 1'b1;
      tick(4);
      chk_en = 1'b1;
      tick(2);
   endtask

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus_idle();
      adr = 8'h00; dout = 8'h00;
      n_reset = 1'b1;
      #5 n_reset = 1'b0;
      do_reset();

      // Directed: write, readback, status port, ignored writes.
      write_txn(8'h30, 1'b0, 1'b1, 8'hA5, 10);
      chk("lit_port_a5", port_data, 8'hA5);
      chk("lit_leds_5a", leds, 8'h5A);
      chk("lit_cnt_1", cnt, 8'd1);
      read_txn(8'h30, 1'b1, 1'b0, 10, got);
      chk("lit_rd_a5", got, 8'hA5);
      chk("lit_cnt_2", cnt, 8'd2);
      read_txn(8'h31, 1'b1, 1'b0, 6, got);
      chk("lit_stat_02", got, 8'h02);
      write_txn(8'h31, 1'b0, 1'b1, 8'h77, 6);
      write_txn(8'h40, 1'b0, 1'b1, 8'h77, 6);
      chk("lit_port_kept", port_data, 8'hA5);
      chk("lit_cnt_3", cnt, 8'd3);

      // Both status bits set at the matching port: no response.
      write_txn(8'h30, 1'b1, 1'b1, 8'h11, 6);
      read_txn(8'h30, 1'b1, 1'b1, 6, got);
      chk("lit_both_cnt", cnt, 8'd3);

      // Timeout then status readback.
      do_reset();
      write_txn(8'h30, 1'b0, 1'b1, 8'hA5, 10);
      read_txn(8'h30, 1'b1, 1'b0, 10, got);
      timeout_txn(8'h30, 1'b1, 1'b0);
      chk("lit_tmo_err", tmo_err, 1);
      read_txn(8'h31, 1'b1, 1'b0, 6, got);
      chk("lit_stat_82", got, 8'h82);

      // New cycle while waiting for a read strobe: restart, no error.
      do_reset();
      start_cycle(8'h30, 1'b1, 1'b0);
      tick(5);
      write_txn(8'h30, 1'b0, 1'b1, 8'h3C, 6);
      chk("lit_restart_port", port_data, 8'h3C);
      chk("lit_restart_err", tmo_err, 0);

      // Reset during DRIVE releases the buffer enable without a clock.
      start_cycle(8'h30, 1'b1, 1'b0);
      pdbin = 1'b1;
      tick(3);
      chk("drv_oe_low", di_oe, 0);
      #3 n_reset = 1'b0;
      #1;
      chk("drv_rst_oe", di_oe, 1);
      chk("drv_rst_di", di, 0);
      chk("drv_rst_port", port_data, 0);
      chk("drv_rst_cnt", cnt, 0);
      do_reset();

      // Random traffic against the model.
      for (int n = 0; n < 60; n++) begin
         logic [7:0] a;
         case ($urandom_range(0, 2))
            0:       a = 8'h30;
            1:       a = 8'h31;
            default: a = 8'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: write_txn(a, ($urandom_range(0, 4) == 0), 1'b1, 8'($urandom), $urandom_range(4, 10));
            1: read_txn(a, 1'b1, ($urandom_range(0, 4) == 0), $urandom_range(4, 10), got);
            2: timeout_txn(a, 1'($urandom), 1'($urandom));
            default: read_txn(8'h31, 1'b1, 1'b0, $urandom_range(4, 10), got);
         endcase
      end

      chk_en = 1'b0;
      tick(1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
